// File: rtl/trig_event_latch.sv
// Sticky trigger-event latch with a 4-phase req/ack snapshot port.
// Events accumulate into sticky/ovf/cnt and are moved into snap_* on capture.
module trig_event_latch #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] trig_in,
    input  logic             clr,
    input  logic             req,
    output logic             ack,
    output logic [WIDTH-1:0] snap_data,
    output logic [WIDTH-1:0] snap_ovf,
    output logic [CNT_W-1:0] snap_count,
    output logic             pending
);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sticky, sticky_nxt;
    logic [WIDTH-1:0] ovf, ovf_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cnt_sat;
    logic             any_trig;
    logic             capture;

    assign any_trig = |trig_in;
    assign capture  = (state == IDLE) && req;
    assign cnt_sat  = (any_trig && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    assign ack      = (state == ACK);

    always_comb begin
        state_nxt  = state;
        sticky_nxt = sticky | trig_in;
        ovf_nxt    = ovf | (sticky & trig_in);
        cnt_nxt    = cnt_sat;
        unique case (state)
            IDLE: if (req) state_nxt = ACK;
            ACK:  if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // capture and clr both empty the accumulators; capture-cycle events
        // land only in the snapshot
        if (capture || clr) begin
            sticky_nxt = '0;
            ovf_nxt    = '0;
            cnt_nxt    = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sticky     <= '0;
            ovf        <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            snap_data  <= '0;
            snap_ovf   <= '0;
            snap_count <= '0;
        end else begin
            state   <= state_nxt;
            sticky  <= sticky_nxt;
            ovf     <= ovf_nxt;
            cnt     <= cnt_nxt;
            pending <= |sticky_nxt;
            if (capture) begin
                snap_data  <= sticky | trig_in;
                snap_ovf   <= ovf | (sticky & trig_in);
                snap_count <= cnt_sat;
            end
        end
    end

endmodule
